serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial multi-bit adder sequencer built around one instance of the team's existing 1-bit full-adder cell.
- Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake.
- Feeds the operands through the cell LSB-first, one bit per clock, with a registered carry.
- Presents sum, carry-out and signed overflow over a second valid/ready handshake.
- Serves as the area-minimal adder for low-rate control arithmetic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- cin  input  1  carry-in, sampled on accept
- out_valid  output  1  result available; held until taken
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- cout  output  1  unsigned carry-out
- ovf  output  1  two's-complement overflow: carry into MSB XOR cout
- busy  output  1  high in RUN

Behaviour:
- Reset:
  - One clock with rst=1 forces IDLE.
  - Clears the a/b shift registers, the sum shift register, carry_q and cnt.
  - Output values: in_ready=1 once in IDLE, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - rst has priority over every other input in every state, including mid-RUN and DONE. A partial result is discarded with no out_valid pulse.
- States: IDLE, RUN, DONE (2-bit encoded register).
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: load a_sh<=a, b_sh<=b, carry_q<=cin, cnt<=0, then go to RUN.
  - in_valid=0: stay in IDLE.
- RUN (exactly WIDTH cycles):
  - Full-adder inputs each cycle: a_sh[0], b_sh[0], carry_q.
  - At each edge:
    - The cell sum bit shifts into sum_sh[WIDTH-1] and sum_sh shifts right.
    - a_sh and b_sh shift right.
    - carry_q<=cell cout.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1:
    - Capture ovf<=carry_q XOR cell cout. carry_q at this point is the carry into the MSB.
    - cout<=cell cout; go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable and driven from registers.
  - On out_ready=1 at an edge: go to IDLE, out_valid drops next cycle.
  - out_ready=0: hold indefinitely; no timeout.
  - Results keep their last values in IDLE until the next completion. sum is sampled only while out_valid=1.
- Latency:
  - Accept edge at cycle k gives out_valid=1 from cycle k+WIDTH+1, i.e. after WIDTH RUN edges.
  - Minimum initiation interval is WIDTH+2 cycles (one IDLE cycle between jobs).
- Handshake rules:
  - in_valid during RUN or DONE is ignored; in_ready=0 there. Inputs are not latched.
  - a, b and cin may change freely after the accept edge.
  - out_ready while out_valid=0 has no effect.
- Arithmetic:
  - sum wraps modulo 2^WIDTH.
  - cout is the unsigned carry; ovf is valid for signed interpretation. Both are always reported.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Decomposition:
- Shared Verilog include header: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. No other shared constants.
- One sub-module: the existing 1-bit full-adder cell fulladder, instantiated once as the datapath.
- Counter, shift registers and FSM live in serial_add_seq itself.

Test Plan (WIDTH=8):
- Reset: rst high 2 cycles -> in_ready=1, out_valid=0, sum=0x00, cout=0, ovf=0, busy=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. out_valid rises exactly 9 cycles after the accept edge; busy high for 8 cycles.
- Signed overflow: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- Backpressure and ignore:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, out_valid held.
  - in_valid pulsed with a=0x55 during RUN and DONE -> ignored; the pending result is unchanged.
- Mid-run reset: accept a=0x3C, b=0x0F; assert rst on the 4th RUN cycle -> IDLE next cycle, all outputs 0, no out_valid. A following job a=0x10, b=0x20, cin=1 -> sum=0x31.
- Back-to-back random: 1000 jobs with random a, b, cin and random out_ready -> {cout,sum} == a+b+cin and ovf matches a signed model on every transfer. Initiation interval is 10 cycles when out_ready=1.

Source files
------------

// File: rtl/serial_add_seq_pkg.sv
// ============================================================================
// Module      : serial_add_seq_pkg
// Description : Shared state encoding for the bit-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_add_seq_pkg

`default_nettype wire

// File: rtl/fulladder.sv
// ============================================================================
// Module      : fulladder
// Description : 1-bit full-adder cell.
//   a_i, b_i, c_i : addend bits and carry-in
//   s_o           : sum bit
//   co_o          : carry-out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule : fulladder

`default_nettype wire

// File: rtl/serial_add_seq.sv
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial WIDTH-bit adder. Operands are accepted over a
//               valid/ready handshake, added LSB-first through one full-adder
//               cell (one bit per clock), and the result is presented over a
//               second valid/ready handshake.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands, sampled on the accept edge
//   out_valid / out_ready: result handshake (valid held until taken)
//   sum, cout, ovf       : sum mod 2^WIDTH, unsigned carry, signed overflow
//   busy                 : high while bits are being processed
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_sh_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;

    fulladder u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_sum),
        .co_o (fa_cout)
    );

    assign last_bit = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                    carry_q  <= fa_cout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // On the MSB cycle carry_q is the carry into the MSB, so
                    // XOR with the cell carry-out gives signed overflow. The
                    // result is copied into separate output registers so the
                    // presented value stays put while the next job shifts.
                    if (last_bit) begin
                        sum_q  <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                        cout_q <= fa_cout;
                        ovf_q  <= carry_q ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule : serial_add_seq

`default_nettype wire

// File: tb/tb_serial_add_seq.sv
// ============================================================================
// Module      : tb_serial_add_seq
// Description : Self-checking bench for serial_add_seq (WIDTH=8). A queue of
//               expected results from an arithmetic model is compared against
//               every cycle the DUT presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    exp_t exp_q[$];

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Arithmetic model: unsigned sum for value/carry, signed sum for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t r;
        int   u;
        int   s;
        byte  sa;
        byte  sb;
        sa = av;
        sb = bv;
        u = int'(av) + int'(bv) + int'(cv);
        s = int'(sa) + int'(sb) + int'(cv);
        r.sum  = u[W-1:0];
        r.cout = (u > 255);
        r.ovf  = (s > 127) || (s < -128);
        return r;
    endfunction

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding job; it is retired when the consumer takes it.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                chk("sum",  64'(sum),  64'(exp_q[0].sum));
                chk("cout", 64'(cout), 64'(exp_q[0].cout));
                chk("ovf",  64'(ovf),  64'(exp_q[0].ovf));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        exp_q.push_back(model(av, bv, cv));
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        if (!out_valid) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = out_valid && out_ready;
            tick();
            n++;
        end
        out_ready = 1'b0;
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int nb;
        int prev;
        bit seen;
        exp_t m;

        // Pin the model with hand-computed values.
        m = model(8'hFF, 8'h01, 1'b0);
        chk("model_ff_01", {m.cout, m.ovf, m.sum}, {1'b1, 1'b0, 8'h00});
        m = model(8'h7F, 8'h01, 1'b0);
        chk("model_7f_01", {m.cout, m.ovf, m.sum}, {1'b0, 1'b1, 8'h80});
        m = model(8'h80, 8'h80, 1'b1);
        chk("model_80_80_1", {m.cout, m.ovf, m.sum}, {1'b1, 1'b1, 8'h01});

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", {in_ready, out_valid, busy, cout, ovf, sum},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});

        // Carry ripple with latency and busy duration
        accept(8'hFF, 8'h01, 1'b0);
        n = 0; nb = 0;
        while (!out_valid && n < 50) begin
            if (busy) nb++;
            tick(); n++;
        end
        chk("latency_edges", 64'(n), 64'd8);
        chk("busy_cycles", 64'(nb), 64'd8);
        chk("ripple_result", {cout, ovf, sum}, {1'b1, 1'b0, 8'h00});
        drain(1'b0);
        chk("valid_drop", 64'(out_valid), 64'd0);

        // Signed overflow, with in_valid ignored during RUN and DONE
        accept(8'h7F, 8'h01, 1'b0);
        tick();
        in_valid = 1'b1; a = 8'h55; b = 8'h55;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; a = 8'h55; b = 8'h55;
            chk("bp_hold", {out_valid, in_ready, cout, ovf, sum},
                {1'b1, 1'b0, 1'b0, 1'b1, 8'h80});
            tick();
        end
        in_valid = 1'b0;
        drain(1'b0);
        chk("idle_retain", {out_valid, in_ready, sum}, {1'b0, 1'b1, 8'h80});

        accept(8'h80, 8'h80, 1'b1);
        wait_valid(n);
        chk("neg_ovf_result", {cout, ovf, sum}, {1'b1, 1'b1, 8'h01});
        drain(1'b0);

        // Mid-run reset on the 4th RUN cycle
        accept(8'h3C, 8'h0F, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("midrun_rst", {in_ready, out_valid, busy, cout, ovf, sum},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= out_valid;
            tick();
        end
        chk("midrun_no_valid", 64'(seen), 64'd0);
        accept(8'h10, 8'h20, 1'b1);
        wait_valid(n);
        chk("post_rst_sum", 64'(sum), 64'h31);
        drain(1'b0);

        // Back-to-back: initiation interval with out_ready held high
        prev = 0;
        for (int j = 0; j < 20; j++) begin
            accept(W'($urandom), W'($urandom), 1'($urandom));
            if (j > 0) chk("init_interval", 64'(acc_cyc - prev), 64'd10);
            prev = acc_cyc;
            drain(1'b0);
        end

        // Random jobs with random backpressure
        for (int j = 0; j < 1000; j++) begin
            accept(W'($urandom), W'($urandom), 1'($urandom));
            drain(1'b1);
        end

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add_seq

`default_nettype wire
